// File: rtl/palette_out.sv
// palette_out: palette lookup, brightness scaling with frame-stepped fade,
// blanking and strobe delay for the pixel stream leaving the tilemap.
module palette_out (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pixel,
  input  logic [1:0]  wr,
  input  logic        cs_ram,
  input  logic        cs_reg,
  input  logic [7:0]  address,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic [7:0]  color_in,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hs_out,
  output logic        vs_out,
  output logic        hb_out,
  output logic        vb_out
);

  typedef enum logic {IDLE, RUN} fade_state_e;

  function automatic logic [4:0] sat16(input logic [4:0] v);
    return (v > 5'd16) ? 5'd16 : v;
  endfunction

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] scale(input logic [7:0] c8, input logic [4:0] b);
    return 8'(({5'd0, c8} * {8'd0, b}) >> 4);
  endfunction

  // Palette storage and read ports
  logic [15:0] pal_mem [256];
  logic [15:0] cpu_rd_q;
  logic [15:0] pix_rd_q;
  logic        unused_pal_bit;

  // Fade / brightness state
  fade_state_e state_q, state_d;
  logic [4:0]  bright_q, bright_d;
  logic [4:0]  target_q, target_d;
  logic [3:0]  period_q, period_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;

  // Pixel pipeline; strobe vectors are {hs, vs, hb, vb}
  logic [3:0]  strb0_q, strb1_q, strb2_q;
  logic [7:0]  r8_q, g8_q, b8_q;
  logic [7:0]  red_q, green_q, blue_q;

  logic        bright_wr, fade_wr, frame_tick, busy;
  logic [4:0]  new_target;
  logic [3:0]  new_period, period_eff, cnt_inc;

  assign unused_pal_bit = pix_rd_q[15];

  assign bright_wr  = cs_reg & ~address[0] & wr[0];
  assign fade_wr    = cs_reg & address[0] & (|wr);
  assign frame_tick = ce_pixel & vblank & ~strb0_q[0];
  assign busy       = (state_q == RUN);
  assign new_target = wr[0] ? sat16(din[4:0]) : target_q;
  assign new_period = wr[1] ? din[11:8] : period_q;
  assign period_eff = (period_q == 4'd0) ? 4'd1 : period_q;
  assign cnt_inc    = frame_cnt_q + 4'd1;

  // Dual-port palette: byte-masked CPU write, registered CPU and pixel reads (old data on collision)
  always_ff @(posedge clk) begin
    if (cs_ram && wr[0]) pal_mem[address][7:0]  <= din[7:0];
    if (cs_ram && wr[1]) pal_mem[address][15:8] <= din[15:8];
    cpu_rd_q <= pal_mem[address];
    if (ce_pixel) pix_rd_q <= pal_mem[color_in];
  end

  // Fade engine and control register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bright_q    <= 5'd16;
      target_q    <= 5'd16;
      period_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bright_q    <= bright_d;
      target_q    <= target_d;
      period_q    <= period_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Fade next-state: BRIGHT write beats FADE write beats frame tick
  always_comb begin
    state_d     = state_q;
    bright_d    = bright_q;
    target_d    = target_q;
    period_d    = period_q;
    frame_cnt_d = frame_cnt_q;
    if (bright_wr) begin
      bright_d = sat16(din[4:0]);
      state_d  = IDLE;
    end else if (fade_wr) begin
      target_d    = new_target;
      period_d    = new_period;
      frame_cnt_d = '0;
      state_d     = (new_target != bright_q) ? RUN : IDLE;
    end else if (state_q == RUN && frame_tick) begin
      if (cnt_inc == period_eff) begin
        frame_cnt_d = '0;
        bright_d    = (bright_q < target_q) ? bright_q + 5'd1 : bright_q - 5'd1;
        if (bright_d == target_q) state_d = IDLE;
      end else begin
        frame_cnt_d = cnt_inc;
      end
    end
  end

  // CPU read mux: registers combinational, palette from the registered port
  always_comb begin
    dout = cpu_rd_q;
    if (cs_reg) begin
      if (address[0]) dout = {busy, 3'd0, period_q, 3'd0, target_q};
      else            dout = {11'd0, bright_q};
    end
  end

  // Pixel pipeline: expand, then scale/blank with strobes delayed to match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strb0_q <= '0;
      strb1_q <= '0;
      strb2_q <= '0;
      r8_q    <= '0;
      g8_q    <= '0;
      b8_q    <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (ce_pixel) begin
      strb0_q <= {hsync, vsync, hblank, vblank};
      strb1_q <= strb0_q;
      strb2_q <= strb1_q;
      r8_q    <= expand5(pix_rd_q[4:0]);
      g8_q    <= expand5(pix_rd_q[9:5]);
      b8_q    <= expand5(pix_rd_q[14:10]);
      if (strb1_q[1] || strb1_q[0]) begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end else begin
        red_q   <= scale(r8_q, bright_q);
        green_q <= scale(g8_q, bright_q);
        blue_q  <= scale(b8_q, bright_q);
      end
    end
  end

  assign red    = red_q;
  assign green  = green_q;
  assign blue   = blue_q;
  assign hs_out = strb2_q[3];
  assign vs_out = strb2_q[2];
  assign hb_out = strb2_q[1];
  assign vb_out = strb2_q[0];

endmodule

// File: tb/tb_palette_out.sv
// Scoreboard bench for palette_out: pixel expectations are queued at issue,
// a monitor pops and compares on every ce_pixel output update.
module tb_palette_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_pixel;
  logic [1:0]  wr;
  logic        cs_ram, cs_reg;
  logic [7:0]  address;
  logic [15:0] din, dout;
  logic [7:0]  color_in;
  logic        hsync, vsync, hblank, vblank;
  logic [7:0]  red, green, blue;
  logic        hs_out, vs_out, hb_out, vb_out;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [3:0] s;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pix_idx  = 0;

  always #5 clk = ~clk;

  palette_out dut (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .wr(wr),
    .cs_ram(cs_ram), .cs_reg(cs_reg), .address(address), .din(din), .dout(dout),
    .color_in(color_in), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .red(red), .green(green), .blue(blue),
    .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: output after ce k belongs to the pixel issued at ce k-2
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (ce_pixel && reset) begin
        #1;
        if (sb.size() == 3) begin
          e = sb.pop_front();
          check($sformatf("pixel%0d", pix_idx),
                {4'd0, red, green, blue, hs_out, vs_out, hb_out, vb_out},
                {4'd0, e.r, e.g, e.b, e.s});
          pix_idx++;
        end
      end
    end
  end

  task automatic cpu_wr(input logic sel_reg, input logic [7:0] a, input logic [15:0] d,
                        input logic [1:0] w);
    @(negedge clk);
    cs_ram = ~sel_reg; cs_reg = sel_reg; address = a; din = d; wr = w;
    @(negedge clk);
    cs_ram = 1'b0; cs_reg = 1'b0; wr = 2'b00;
  endtask

  task automatic reg_rd(input string name, input logic a0, input logic [15:0] exp);
    @(negedge clk);
    cs_reg = 1'b1; address = {7'd0, a0};
    #1 check(name, {16'd0, dout}, {16'd0, exp});
    cs_reg = 1'b0;
  endtask

  task automatic ram_rd(input string name, input logic [7:0] a, input logic [15:0] exp);
    @(negedge clk);
    cs_reg = 1'b0; address = a;
    @(posedge clk);
    #1 check(name, {16'd0, dout}, {16'd0, exp});
  endtask

  // One pixel with optional simultaneous CPU write (palette or register)
  task automatic pix_x(input logic [7:0] c, input logic [3:0] s,
                       input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                       input logic wen, input logic wsel_reg, input logic [7:0] wa,
                       input logic [15:0] wd);
    exp_t e;
    @(negedge clk);
    color_in = c; {hsync, vsync, hblank, vblank} = s; ce_pixel = 1'b1;
    if (wen) begin
      cs_ram = ~wsel_reg; cs_reg = wsel_reg; address = wa; din = wd; wr = 2'b11;
    end
    e.s = s;
    if (s[1] || s[0]) begin e.r = 8'd0; e.g = 8'd0; e.b = 8'd0; end
    else begin e.r = er; e.g = eg; e.b = eb; end
    sb.push_back(e);
    @(negedge clk);
    ce_pixel = 1'b0; cs_ram = 1'b0; cs_reg = 1'b0; wr = 2'b00;
  endtask

  task automatic pix(input logic [7:0] c, input logic [3:0] s,
                     input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    pix_x(c, s, er, eg, eb, 1'b0, 1'b0, 8'd0, 16'd0);
  endtask

  // Entry 0 is black, so these keep the pipeline neutral across brightness changes
  task automatic flush();
    pix(8'd0, 4'b0000, 8'd0, 8'd0, 8'd0);
    pix(8'd0, 4'b0000, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic vb_rise();
    pix(8'd0, 4'b0001, 8'd0, 8'd0, 8'd0);
    pix(8'd0, 4'b0000, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ce_pixel = 1'b0; wr = 2'b00; cs_ram = 1'b0; cs_reg = 1'b0;
    address = 8'd0; din = 16'd0; color_in = 8'd0;
    {hsync, vsync, hblank, vblank} = 4'b0000;
    #23;
    check("reset_outputs", {4'd0, red, green, blue, hs_out, vs_out, hb_out, vb_out}, 32'd0);
    @(negedge clk); reset = 1'b1;
    reg_rd("reset_bright", 1'b0, 16'h0010);
    reg_rd("reset_fade",   1'b1, 16'h0010);

    // Palette byte writes and readback
    cpu_wr(1'b0, 8'd5, 16'h7C1F, 2'b11);
    ram_rd("pal5_full", 8'd5, 16'h7C1F);
    cpu_wr(1'b0, 8'd5, 16'h0300, 2'b10);
    ram_rd("pal5_hibyte", 8'd5, 16'h031F);

    cpu_wr(1'b0, 8'd0, 16'h0000, 2'b11);
    cpu_wr(1'b0, 8'd3, 16'h001F, 2'b11);
    cpu_wr(1'b0, 8'd7, 16'h7FFF, 2'b11);
    cpu_wr(1'b0, 8'd4, 16'h5101, 2'b11);
    cpu_wr(1'b0, 8'd9, 16'h001F, 2'b11);

    // Lookup, expansion and strobe alignment at full brightness
    pix(8'd3, 4'b1000, 8'd255, 8'd0,   8'd0);
    pix(8'd4, 4'b0100, 8'd8,   8'd66,  8'd165);
    pix(8'd7, 4'b0000, 8'd255, 8'd255, 8'd255);
    pix(8'd0, 4'b1100, 8'd0,   8'd0,   8'd0);

    // Half brightness and blanking
    flush();
    cpu_wr(1'b1, 8'd0, 16'h0008, 2'b01);
    reg_rd("bright8", 1'b0, 16'h0008);
    pix(8'd7, 4'b0000, 8'd127, 8'd127, 8'd127);
    pix(8'd4, 4'b1000, 8'd4,   8'd33,  8'd82);
    pix(8'd7, 4'b0010, 8'd0,   8'd0,   8'd0);
    pix(8'd3, 4'b0001, 8'd0,   8'd0,   8'd0);
    pix(8'd7, 4'b0000, 8'd127, 8'd127, 8'd127);

    // Saturating BRIGHT write
    flush();
    cpu_wr(1'b1, 8'd0, 16'h0014, 2'b01);
    reg_rd("bright_sat", 1'b0, 16'h0010);

    // Read-during-write on entry 9: pixel sees old data, next one sees new
    pix_x(8'd9, 4'b0000, 8'd255, 8'd0, 8'd0, 1'b1, 1'b0, 8'd9, 16'h03E0);
    pix(8'd9, 4'b0000, 8'd0, 8'd255, 8'd0);
    ram_rd("pal9_new", 8'd9, 16'h03E0);

    // Fade 16 -> 12, one step every 2 frames
    flush();
    cpu_wr(1'b1, 8'd1, 16'h020C, 2'b11);
    reg_rd("fade_busy", 1'b1, 16'h820C);
    for (int r = 1; r <= 8; r++) begin
      vb_rise();
      reg_rd($sformatf("fade_rise%0d", r), 1'b0, 16'(16 - r / 2));
    end
    reg_rd("fade_done", 1'b1, 16'h020C);

    // BRIGHT write on the 3rd rise aborts
    cpu_wr(1'b1, 8'd0, 16'h0010, 2'b01);
    cpu_wr(1'b1, 8'd1, 16'h020C, 2'b11);
    vb_rise();
    vb_rise();
    reg_rd("abort_pre", 1'b0, 16'h000F);
    pix_x(8'd0, 4'b0001, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 8'd0, 16'h000A);
    pix(8'd0, 4'b0000, 8'd0, 8'd0, 8'd0);
    reg_rd("abort_bright", 1'b0, 16'h000A);
    reg_rd("abort_idle",   1'b1, 16'h020C);
    vb_rise();
    reg_rd("abort_hold", 1'b0, 16'h000A);

    // Period 1: tick and BRIGHT write on the same clk -> write wins, no step
    cpu_wr(1'b1, 8'd1, 16'h0104, 2'b11);
    reg_rd("p1_busy", 1'b1, 16'h8104);
    vb_rise();
    reg_rd("p1_step", 1'b0, 16'h0009);
    pix_x(8'd0, 4'b0001, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 8'd0, 16'h000C);
    pix(8'd0, 4'b0000, 8'd0, 8'd0, 8'd0);
    reg_rd("p1_collide", 1'b0, 16'h000C);
    reg_rd("p1_idle",    1'b1, 16'h0104);

    // Period 0 behaves as 1; upward fade 12 -> 14
    cpu_wr(1'b1, 8'd1, 16'h000E, 2'b11);
    vb_rise();
    reg_rd("p0_step1", 1'b0, 16'h000D);
    vb_rise();
    reg_rd("p0_step2", 1'b0, 16'h000E);
    reg_rd("p0_idle",  1'b1, 16'h000E);
    cpu_wr(1'b1, 8'd1, 16'h000E, 2'b11);
    reg_rd("fade_same_idle", 1'b1, 16'h000E);

    // Reset mid-frame with non-zero pixels in flight (bright 14: 255*14>>4 = 223)
    pix(8'd7, 4'b1000, 8'd223, 8'd223, 8'd223);
    pix(8'd7, 4'b1000, 8'd223, 8'd223, 8'd223);
    pix(8'd7, 4'b1000, 8'd223, 8'd223, 8'd223);
    @(negedge clk);
    #2 reset = 1'b0;
    sb.delete();
    #1 check("midreset_outputs", {4'd0, red, green, blue, hs_out, vs_out, hb_out, vb_out}, 32'd0);
    reg_rd("midreset_bright", 1'b0, 16'h0010);
    reg_rd("midreset_fade",   1'b1, 16'h0010);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
